// File: rtl/pyr_line_window_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pyr_pkg
//  Purpose  : Shared definitions for the pyramid line-window block:
//             FSM state encodings, counter-width helpers and the tap
//             slice helper used to place taps in the packed window bus.
//  Revision : 1.0  initial parametrised release
// ============================================================================
package pyr_pkg;

    // FSM state encodings (explicit 1-bit width)
    localparam logic [0:0] c_WAIT_SOF = 1'b0;
    localparam logic [0:0] c_RUN      = 1'b1;

    // Width of a counter that must hold 0..bound-1; never narrower than 1 bit.
    function automatic int unsigned cnt_w(input int unsigned bound);
        return (bound > 1) ? $clog2(bound) : 1;
    endfunction

    function automatic int unsigned col_w(input int unsigned cols);
        return cnt_w(cols);
    endfunction

    function automatic int unsigned row_w(input int unsigned rows);
        return cnt_w(rows);
    endfunction

    // LSB position of tap k in a packed bus of WIDTH-bit taps.
    function automatic int unsigned tap_lsb(input int unsigned k, input int unsigned width);
        return k * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pyr_line_window_if.sv
`default_nettype none
// ============================================================================
//  Module   : pyr_line_window_if
//  Purpose  : Pixel-in / window-out signal bundle for pyr_line_window.
//  Signals  : in_sof, in_valid, in_data          (source -> window block)
//             win_valid, win_col, out_row, out_col,
//             row_odd, col_odd, frame_done, sof_err (window block -> sink)
//  Modports : master = pixel source / window consumer, slave = the block.
//  Revision : 1.0  initial parametrised release
// ============================================================================
interface pyr_line_window_if #(
    parameter int WIDTH = 8,
    parameter int COLS  = 752,
    parameter int ROWS  = 480,
    parameter int KROWS = 5
);
    import pyr_pkg::*;

    localparam int COL_W = col_w(COLS);
    localparam int ROW_W = row_w(ROWS);

    logic                   in_sof;
    logic                   in_valid;
    logic [WIDTH-1:0]       in_data;
    logic                   win_valid;
    logic [KROWS*WIDTH-1:0] win_col;
    logic [ROW_W-1:0]       out_row;
    logic [COL_W-1:0]       out_col;
    logic                   row_odd;
    logic                   col_odd;
    logic                   frame_done;
    logic                   sof_err;

    modport master (
        output in_sof, in_valid, in_data,
        input  win_valid, win_col, out_row, out_col,
        input  row_odd, col_odd, frame_done, sof_err
    );

    modport slave (
        input  in_sof, in_valid, in_data,
        output win_valid, win_col, out_row, out_col,
        output row_odd, col_odd, frame_done, sof_err
    );

endinterface
`default_nettype wire

// File: rtl/pyr_line_window_delay.sv
`default_nettype none
// ============================================================================
//  Module   : pyr_line_delay
//  Purpose  : One line of delay: a DEPTH-deep, WIDTH-wide delay advanced
//             only when ce is high. Built as a circular buffer with
//             read-before-write, so dout is the sample written DEPTH
//             enabled cycles earlier.
//  Ports    : clk, rst (sync, active high; resets the pointer only),
//             ce (advance), din (sample in), dout (delayed sample).
//  Revision : 1.0  initial parametrised release
// ============================================================================
module pyr_line_delay
    import pyr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 752
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int PTR_W = cnt_w(DEPTH);
    localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (ce) begin
            r_ptr <= (r_ptr == c_PTR_LAST) ? '0 : r_ptr + PTR_W'(1);
        end
    end

    // Storage carries no reset: contents are don't-care until refilled.
    always_ff @(posedge clk) begin
        if (ce) begin
            r_mem[r_ptr] <= din;
        end
    end

    assign dout = r_mem[r_ptr];

endmodule
`default_nettype wire

// File: rtl/pyr_line_window.sv
`default_nettype none
// ============================================================================
//  Module   : pyr_line_window
//  Purpose  : Raster line buffer for the pyramid kernel stage. Holds
//             KROWS-1 full lines and emits one vertically aligned
//             KROWS-tall column per accepted pixel, registered one cycle
//             after the pixel, with row/column position and odd flags.
//  Ports    : clk, rst (sync, active high)
//             bus (pyr_line_window_if.slave): in_sof/in_valid/in_data in;
//             win_valid/win_col/out_row/out_col/row_odd/col_odd/
//             frame_done/sof_err out. Tap k sits at win_col[k*WIDTH +: WIDTH],
//             k=0 oldest row, k=KROWS-1 current row.
//  Options  : PYR_LINE_WINDOW_REPLICATE_EN - top-border replication: every
//             accepted pixel produces a window, missing upper rows repeat
//             the oldest available row.
//  Revision : 1.0  initial parametrised release
// ============================================================================
module pyr_line_window
    import pyr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int COLS  = 752,
    parameter int ROWS  = 480,
    parameter int KROWS = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    pyr_line_window_if.slave        bus
);

    localparam int COL_W  = col_w(COLS);
    localparam int ROW_W  = row_w(ROWS);
    localparam int FILL_W = cnt_w(KROWS);

    localparam logic [COL_W-1:0]  c_COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  c_ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [FILL_W-1:0] c_FILL_MAX = FILL_W'(KROWS - 1);

    logic [0:0]        r_state;
    logic [COL_W-1:0]  r_col;      // position of the next expected pixel
    logic [ROW_W-1:0]  r_row;
    logic [FILL_W-1:0] r_fill;     // completed lines held, saturating

    logic              w_accept;
    logic              w_restart;
    logic              w_sof_err;
    logic              w_line_end;
    logic              w_frame_end;
    logic              w_win_valid;
    logic [COL_W-1:0]  w_col;      // position of the pixel on the input now
    logic [ROW_W-1:0]  w_row;
    logic [FILL_W-1:0] w_fill;

    // w_depth[d] is the pixel d lines above the current one, same column.
    logic [WIDTH-1:0]       w_depth [KROWS];
    logic [KROWS*WIDTH-1:0] w_win;

    // Outside a frame only a start-of-frame pixel is taken.
    assign w_accept  = bus.in_valid & ((r_state == c_RUN) | bus.in_sof);
    // Any qualified sof turns the current pixel into (0,0) with an empty buffer.
    assign w_restart = bus.in_valid & bus.in_sof;
    assign w_sof_err = w_restart & (r_state == c_RUN) &
                       ((r_row != '0) | (r_col != '0));

    assign w_col  = w_restart ? '0 : r_col;
    assign w_row  = w_restart ? '0 : r_row;
    assign w_fill = w_restart ? '0 : r_fill;

    assign w_line_end  = (w_col == c_COL_LAST);
    assign w_frame_end = w_line_end & (w_row == c_ROW_LAST);

    // ------------------------------------------------------------------
    // Line-delay cascade
    // ------------------------------------------------------------------
    assign w_depth[0] = bus.in_data;

    for (genvar g = 0; g < KROWS - 1; g++) begin : g_delay
        logic [WIDTH-1:0] w_din;
        logic [WIDTH-1:0] w_dout;

        if (g == 0) begin : g_first
            assign w_din = bus.in_data;
        end else begin : g_chain
            assign w_din = g_delay[g-1].w_dout;
        end

        pyr_line_delay #(
            .WIDTH (WIDTH),
            .DEPTH (COLS)
        ) u_delay (
            .clk  (clk),
            .rst  (rst),
            .ce   (w_accept),
            .din  (w_din),
            .dout (w_dout)
        );

        assign w_depth[g+1] = w_dout;
    end

    // ------------------------------------------------------------------
    // Tap selection
    // ------------------------------------------------------------------
    for (genvar k = 0; k < KROWS; k++) begin : g_tap
`ifdef PYR_LINE_WINDOW_REPLICATE_EN
        // Depth is clamped to the lines actually held, so at the top border
        // the oldest valid row is repeated upward.
        localparam logic [FILL_W-1:0] c_DEPTH = FILL_W'(KROWS - 1 - k);
        logic [FILL_W-1:0] w_sel;
        assign w_sel = (w_fill < c_DEPTH) ? w_fill : c_DEPTH;
        assign w_win[tap_lsb(k, WIDTH) +: WIDTH] = w_depth[w_sel];
`else
        assign w_win[tap_lsb(k, WIDTH) +: WIDTH] = w_depth[KROWS - 1 - k];
`endif
    end

`ifdef PYR_LINE_WINDOW_REPLICATE_EN
    assign w_win_valid = w_accept;
`else
    assign w_win_valid = w_accept & (w_fill == c_FILL_MAX);
`endif

    // ------------------------------------------------------------------
    // Position counters, fill counter and FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_WAIT_SOF;
            r_col   <= '0;
            r_row   <= '0;
            r_fill  <= '0;
        end else if (w_accept) begin
            if (w_frame_end) begin
                r_state <= c_WAIT_SOF;
                r_col   <= '0;
                r_row   <= '0;
            end else begin
                r_state <= c_RUN;
                if (w_line_end) begin
                    r_col <= '0;
                    r_row <= w_row + ROW_W'(1);
                end else begin
                    r_col <= w_col + COL_W'(1);
                    r_row <= w_row;
                end
            end
            if (w_line_end && (w_fill != c_FILL_MAX)) begin
                r_fill <= w_fill + FILL_W'(1);
            end else begin
                r_fill <= w_fill;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.win_valid  <= 1'b0;
            bus.win_col    <= '0;
            bus.out_row    <= '0;
            bus.out_col    <= '0;
            bus.row_odd    <= 1'b0;
            bus.col_odd    <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.sof_err    <= 1'b0;
        end else begin
            bus.win_valid  <= w_win_valid;
            // A restarted pixel is (0,0), so it can never also close a frame.
            bus.frame_done <= w_accept & w_frame_end;
            bus.sof_err    <= w_sof_err;
            if (w_accept) begin
                bus.win_col <= w_win;
                bus.out_row <= w_row;
                bus.out_col <= w_col;
                bus.row_odd <= w_row[0];
                bus.col_odd <= w_col[0];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pyr_line_window.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pyr_line_window
//  Purpose  : Directed self-checking bench for pyr_line_window with
//             WIDTH=8, COLS=4, ROWS=4, KROWS=3 and pixel value 16*row+col.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pyr_line_window;

    localparam int WIDTH = 8;
    localparam int COLS  = 4;
    localparam int ROWS  = 4;
    localparam int KROWS = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    pyr_line_window_if #(.WIDTH(WIDTH), .COLS(COLS), .ROWS(ROWS), .KROWS(KROWS)) bus ();

    pyr_line_window #(
        .WIDTH (WIDTH),
        .COLS  (COLS),
        .ROWS  (ROWS),
        .KROWS (KROWS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Pixel value at (r,c).
    function automatic logic [7:0] pix(input int r, input int c);
        return 8'(16 * r + c);
    endfunction

    // Expected window for pixel (r,c) of a frame that started cleanly.
    function automatic logic [23:0] exp_win(input int r, input int c);
        logic [23:0] w;
        int src;
        w = '0;
        for (int k = 0; k < KROWS; k++) begin
            src = r - (KROWS - 1 - k);
`ifdef PYR_LINE_WINDOW_REPLICATE_EN
            if (src < 0) src = 0;
`endif
            w[k*8 +: 8] = pix(src, c);
        end
        return w;
    endfunction

    function automatic logic exp_valid(input int r);
`ifdef PYR_LINE_WINDOW_REPLICATE_EN
        return 1'b1;
`else
        return (r >= KROWS - 1);
`endif
    endfunction

    // Present one input cycle, then land 1 time unit after the edge.
    task automatic step(input logic v, input logic sof, input logic [7:0] d);
        bus.in_valid = v;
        bus.in_sof   = sof;
        bus.in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        n_checks++;
        if (bus.win_valid !== 1'b0 || bus.frame_done !== 1'b0 || bus.sof_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_strobes got valid=%b done=%b err=%b want 0 0 0",
                     bus.win_valid, bus.frame_done, bus.sof_err);
        end
        n_checks++;
        if (bus.win_col !== 24'h0 || bus.out_row !== 2'd0 || bus.out_col !== 2'd0 ||
            bus.row_odd !== 1'b0 || bus.col_odd !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data got col=%h row=%0d c=%0d want all 0",
                     bus.win_col, bus.out_row, bus.out_col);
        end
    endtask

    task automatic test_ignore_no_sof();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, pix(2, i % 4));
            n_checks++;
            if (bus.win_valid !== 1'b0 || bus.out_col !== 2'd0 || bus.out_row !== 2'd0) begin
                n_fail++;
                $display("FAIL ignore_no_sof i=%0d got valid=%b row=%0d col=%0d want 0 0 0",
                         i, bus.win_valid, bus.out_row, bus.out_col);
            end
        end
    endtask

    task automatic test_continuous();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                step(1'b1, (r == 0 && c == 0), pix(r, c));
                n_checks++;
                if (bus.win_valid !== exp_valid(r)) begin
                    n_fail++;
                    $display("FAIL cont_valid (%0d,%0d) got %b want %b", r, c, bus.win_valid, exp_valid(r));
                end
                if (exp_valid(r)) begin
                    n_checks++;
                    if (bus.win_col !== exp_win(r, c) || bus.out_row !== 2'(r) || bus.out_col !== 2'(c) ||
                        bus.row_odd !== r[0] || bus.col_odd !== c[0]) begin
                        n_fail++;
                        $display("FAIL cont_win (%0d,%0d) got %h r%0d c%0d o%b%b want %h r%0d c%0d",
                                 r, c, bus.win_col, bus.out_row, bus.out_col, bus.row_odd, bus.col_odd,
                                 exp_win(r, c), r, c);
                    end
                end
`ifndef PYR_LINE_WINDOW_REPLICATE_EN
                if (r == 2 && c == 0) begin
                    n_checks++;
                    if (bus.win_col !== 24'h201000) begin
                        n_fail++;
                        $display("FAIL cont_first_win got %h want 201000", bus.win_col);
                    end
                end
`endif
                n_checks++;
                if (bus.frame_done !== (r == ROWS - 1 && c == COLS - 1)) begin
                    n_fail++;
                    $display("FAIL cont_done (%0d,%0d) got %b", r, c, bus.frame_done);
                end
            end
        end
        step(1'b0, 1'b0, 8'h00);
        n_checks++;
        if (bus.frame_done !== 1'b0 || bus.win_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_after got done=%b valid=%b want 0 0", bus.frame_done, bus.win_valid);
        end
    endtask

    task automatic test_stall();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                step(1'b1, (r == 0 && c == 0), pix(r, c));
                n_checks++;
                if (bus.win_valid !== exp_valid(r) ||
                    (exp_valid(r) && bus.win_col !== exp_win(r, c)) ||
                    bus.frame_done !== (r == ROWS - 1 && c == COLS - 1)) begin
                    n_fail++;
                    $display("FAIL stall_win (%0d,%0d) got v=%b %h d=%b want v=%b %h",
                             r, c, bus.win_valid, bus.win_col, bus.frame_done, exp_valid(r), exp_win(r, c));
                end
                step(1'b0, 1'b1, 8'hEE);
                n_checks++;
                if (bus.win_valid !== 1'b0 || bus.frame_done !== 1'b0 || bus.sof_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_bubble (%0d,%0d) got v=%b d=%b e=%b want 0 0 0",
                             r, c, bus.win_valid, bus.frame_done, bus.sof_err);
                end
            end
        end
    endtask

    task automatic test_sof_err();
        for (int i = 0; i < 2 * COLS + 1; i++) begin
            step(1'b1, (i == 0), pix(i / COLS, i % COLS));
        end
        n_checks++;
        if (bus.win_valid !== 1'b1 || bus.out_row !== 2'd2 || bus.out_col !== 2'd0) begin
            n_fail++;
            $display("FAIL sof_err_pre got v=%b r%0d c%0d want 1 r2 c0", bus.win_valid, bus.out_row, bus.out_col);
        end
        // Early sof where (2,1) was expected: becomes the new (0,0).
        step(1'b1, 1'b1, pix(0, 0));
        n_checks++;
        if (bus.sof_err !== 1'b1 || bus.out_row !== 2'd0 || bus.out_col !== 2'd0 ||
            bus.win_valid !== exp_valid(0)) begin
            n_fail++;
            $display("FAIL sof_err_pulse got e=%b r%0d c%0d v=%b want 1 r0 c0 v=%b",
                     bus.sof_err, bus.out_row, bus.out_col, bus.win_valid, exp_valid(0));
        end
        for (int i = 1; i < ROWS * COLS; i++) begin
            step(1'b1, 1'b0, pix(i / COLS, i % COLS));
            n_checks++;
            if (bus.sof_err !== 1'b0 || bus.win_valid !== exp_valid(i / COLS) ||
                (exp_valid(i / COLS) && bus.win_col !== exp_win(i / COLS, i % COLS)) ||
                bus.frame_done !== (i == ROWS * COLS - 1)) begin
                n_fail++;
                $display("FAIL sof_err_refill (%0d,%0d) got e=%b v=%b %h d=%b want v=%b %h",
                         i / COLS, i % COLS, bus.sof_err, bus.win_valid, bus.win_col, bus.frame_done,
                         exp_valid(i / COLS), exp_win(i / COLS, i % COLS));
            end
        end
    endtask

    task automatic test_sof_last();
        for (int i = 0; i < ROWS * COLS - 1; i++) begin
            step(1'b1, (i == 0), pix(i / COLS, i % COLS));
        end
        step(1'b1, 1'b1, pix(0, 0));
        n_checks++;
        if (bus.sof_err !== 1'b1 || bus.frame_done !== 1'b0 ||
            bus.out_row !== 2'd0 || bus.out_col !== 2'd0) begin
            n_fail++;
            $display("FAIL sof_last got e=%b d=%b r%0d c%0d want 1 0 r0 c0",
                     bus.sof_err, bus.frame_done, bus.out_row, bus.out_col);
        end
        step(1'b1, 1'b0, pix(0, 1));
        n_checks++;
        if (bus.sof_err !== 1'b0 || bus.frame_done !== 1'b0 || bus.out_col !== 2'd1) begin
            n_fail++;
            $display("FAIL sof_last_next got e=%b d=%b c%0d want 0 0 c1",
                     bus.sof_err, bus.frame_done, bus.out_col);
        end
    endtask

    task automatic test_rst_mid();
        rst = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 3 * COLS + 1; i++) begin
            step(1'b1, (i == 0), pix(i / COLS, i % COLS));
        end
        rst = 1'b1;
        step(1'b1, 1'b0, pix(3, 1));
        rst = 1'b0;
        n_checks++;
        if (bus.win_valid !== 1'b0 || bus.win_col !== 24'h0 || bus.out_row !== 2'd0 ||
            bus.out_col !== 2'd0 || bus.row_odd !== 1'b0 || bus.col_odd !== 1'b0 ||
            bus.frame_done !== 1'b0 || bus.sof_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs got v=%b %h r%0d c%0d want all 0",
                     bus.win_valid, bus.win_col, bus.out_row, bus.out_col);
        end
        // In WAIT_SOF these two pixels must not move the position.
        step(1'b1, 1'b0, pix(3, 2));
        step(1'b1, 1'b0, pix(3, 3));
        n_checks++;
        if (bus.win_valid !== 1'b0 || bus.out_col !== 2'd0 || bus.out_row !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_mid_wait got v=%b r%0d c%0d want 0 r0 c0",
                     bus.win_valid, bus.out_row, bus.out_col);
        end
        for (int i = 0; i < ROWS * COLS; i++) begin
            step(1'b1, (i == 0), pix(i / COLS, i % COLS));
            n_checks++;
            if (bus.win_valid !== exp_valid(i / COLS) || bus.sof_err !== 1'b0 ||
                (exp_valid(i / COLS) && bus.win_col !== exp_win(i / COLS, i % COLS)) ||
                bus.frame_done !== (i == ROWS * COLS - 1)) begin
                n_fail++;
                $display("FAIL rst_mid_restart (%0d,%0d) got v=%b %h d=%b e=%b want v=%b %h",
                         i / COLS, i % COLS, bus.win_valid, bus.win_col, bus.frame_done, bus.sof_err,
                         exp_valid(i / COLS), exp_win(i / COLS, i % COLS));
            end
        end
    endtask

`ifdef PYR_LINE_WINDOW_REPLICATE_EN
    task automatic test_replicate();
        for (int i = 0; i < 2 * COLS; i++) begin
            step(1'b1, (i == 0), pix(i / COLS, i % COLS));
            if (i == 2) begin
                n_checks++;
                if (bus.win_valid !== 1'b1 || bus.win_col !== 24'h020202) begin
                    n_fail++;
                    $display("FAIL rep_row0 got v=%b %h want 1 020202", bus.win_valid, bus.win_col);
                end
            end
            if (i == COLS + 1) begin
                n_checks++;
                if (bus.row_odd !== 1'b1 || bus.col_odd !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rep_odd11 got %b%b want 11", bus.row_odd, bus.col_odd);
                end
            end
            if (i == COLS + 2) begin
                n_checks++;
                if (bus.win_col !== 24'h120202 || bus.row_odd !== 1'b1 || bus.col_odd !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rep_row1 got %h o%b%b want 120202 o10",
                             bus.win_col, bus.row_odd, bus.col_odd);
                end
            end
        end
        rst = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
    endtask
`endif

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_ignore_no_sof();
        test_continuous();
        test_stall();
        test_sof_err();
        test_sof_last();
        test_rst_mid();
`ifdef PYR_LINE_WINDOW_REPLICATE_EN
        test_replicate();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pyr_line_window.md
Name: pyr_line_window

Overview:
- Parametrised successor to the fixed 5-row pyramid line buffer.
- Accepts a raster pixel stream with a valid qualifier and holds KROWS-1 full lines in delay buffers.
- Emits one vertically aligned KROWS-tall pixel column per accepted pixel, with row/column position and even/odd decimation flags.
- Feeds the Gaussian/pyramid kernel stage; image size, pixel width and kernel height are all parameters.

Parameters:
- WIDTH, 8, pixel bit width.
- COLS, 752, pixels per line.
- ROWS, 480, lines per frame.
- KROWS, 5, window height (number of taps); legal range 2..8.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- in_sof  in  1  start of frame; qualified by in_valid; marks pixel (0,0).
- in_valid  in  1  pixel strobe; the block never back-pressures.
- in_data  in  WIDTH  pixel value.
- win_valid  out  1  win_col/position outputs valid this cycle.
- win_col  out  KROWS*WIDTH  tap k at bits [k*WIDTH +: WIDTH]; k=0 is the oldest row, k=KROWS-1 is the current row.
- out_row  out  clog2(ROWS)  row index of the current-row tap.
- out_col  out  clog2(COLS)  column index.
- row_odd  out  1  out_row[0].
- col_odd  out  1  out_col[0].
- frame_done  out  1  one-cycle pulse coincident with output of pixel (ROWS-1, COLS-1).
- sof_err  out  1  one-cycle pulse when in_sof arrives mid-frame.

Behaviour:
- Reset values:
  - All outputs 0.
  - Row and column counters 0.
  - Fill counter 0; line buffer contents don't-care.
  - State WAIT_SOF.
- FSM states and transitions:
  - WAIT_SOF: pixels are ignored unless in_sof=1. On in_valid & in_sof, accept the pixel as (0,0) and go to RUN.
  - RUN: each in_valid advances col; col wraps at COLS-1 and row increments. On accepting (ROWS-1, COLS-1), pulse frame_done and return to WAIT_SOF.
  - RUN with in_valid & in_sof at a position other than (0,0): pulse sof_err, restart counters at (0,0) with this pixel, clear the fill counter.
- Line buffers:
  - KROWS-1 cascaded COLS-deep delays.
  - Shift only on accepted pixels; in_valid low freezes everything.
- Latency: outputs are registered, 1 cycle after the accepted pixel. Stalls insert bubbles (win_valid=0) with no data loss.
- Fill: the fill counter saturates at KROWS-1 and increments at each completed line.
- win_valid (normal mode): accepted pixel AND fill == KROWS-1. Rows 0..KROWS-2 therefore produce no output.
- Arithmetic: no arithmetic on pixel data. Counter widths are $clog2 of the bound; counters must not overflow when COLS or ROWS is a power of two.
- Boundary conditions:
  - in_sof on the final pixel of a frame: sof_err fires and that pixel starts the new frame; frame_done is not pulsed.
  - rst mid-frame: immediate return to WAIT_SOF and all outputs to 0 on the next cycle.

Optional Feature:
- Macro: PYR_LINE_WINDOW_REPLICATE_EN.
- Defined: top-border replication.
  - win_valid is asserted for every accepted pixel from row 0.
  - Tap k takes line-delay depth min(KROWS-1-k, fill), so missing upper rows repeat the oldest available row.
  - At row 0, all taps equal in_data.
- Undefined: behaviour exactly as under Behaviour; no mux logic is synthesised.

Decomposition:
- Package pyr_pkg holds:
  - FSM state enum (WAIT_SOF, RUN).
  - Localparams COL_W = $clog2(COLS) and ROW_W = $clog2(ROWS), as functions.
  - Tap slice helper.
- Sub-module pyr_line_delay: a single COLS-deep, WIDTH-wide delay with clock enable, instantiated KROWS-1 times via generate.

Test Plan:
All scenarios use WIDTH=8, COLS=4, ROWS=4, KROWS=3 and in_data = 16*row + col.
- Continuous frame starting with in_sof:
  - no win_valid for rows 0-1;
  - first win_valid 1 cycle after pixel (2,0), with win_col = {0x20, 0x10, 0x00} (k=2..0);
  - frame_done 1 cycle after pixel (3,3).
- in_valid toggled 1-on/1-off over a whole frame: identical win_col sequence to the continuous case, with bubbles between outputs.
- Pixels without in_sof after reset are ignored (no outputs); first in_sof starts the frame at (0,0).
- in_sof at (2,1):
  - sof_err pulses;
  - out_row/out_col restart at 0;
  - win_valid stays low until the new row 2.
- rst asserted at (3,1): the next cycle has all outputs 0 and the state is WAIT_SOF; a following in_sof restarts cleanly.
- With PYR_LINE_WINDOW_REPLICATE_EN defined:
  - pixel (0,2) gives win_col {0x02, 0x02, 0x02};
  - pixel (1,2) gives {0x12, 0x02, 0x02};
  - row_odd/col_odd track out_row/out_col bit 0.
